// File: rtl/coco_muldiv_seq_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// State encoding and default operand width.
package coco_muldiv_seq_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/coco_muldiv_step.sv
// One shift-add multiply or restoring-divide iteration.
// acc = {upper, lower}; divide shifts the quotient bit into lower.
module coco_muldiv_step
  import coco_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 mul_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shf;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem;
  logic             ge;

  assign sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
              + (acc_i[0] ? {1'b0, opnd_i} : '0);

  // Remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
  assign shf  = acc_i[2*WIDTH-1:WIDTH-1];
  assign ge   = shf >= {1'b0, opnd_i};
  assign diff = shf[WIDTH-1:0] - opnd_i;
  assign rem  = ge ? diff : shf[WIDTH-1:0];

  assign acc_o = mul_i ? {sum, acc_i[WIDTH-1:1]}
                       : {rem, acc_i[WIDTH-2:0], ge};

endmodule

// File: rtl/coco_muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO pair.
// Also serves MTHI/MTLO writes and the MFHI/MFLO read mux.
module coco_muldiv_seq
  import coco_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MorD,
  input  logic             HorL,
  input  logic             Sign,
  input  logic             We,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ready,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] Out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               mul_q;
  logic               negp_q;
  logic               negr_q;
  logic               dz_q;
  logic               ready_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign a_neg = ~Sign & A[WIDTH-1];
  assign b_neg = ~Sign & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  assign prod_fix = negp_q ? -acc_q : acc_q;
  assign quo_fix  = negp_q ? -acc_q[WIDTH-1:0]
                           : acc_q[WIDTH-1:0];
  assign rem_fix  = negr_q ? -acc_q[2*WIDTH-1:WIDTH]
                           : acc_q[2*WIDTH-1:WIDTH];

  coco_muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mul_i  (mul_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_d)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_q   <= 1'b0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_q <= ST_CALC;
            cnt_q   <= '0;
            mul_q   <= MorD;
            negp_q  <= a_neg ^ b_neg;
            negr_q  <= a_neg;
            dz_q    <= (B == '0);
            acc_q   <= {{WIDTH{1'b0}}, MorD ? b_mag : a_mag};
            opnd_q  <= MorD ? a_mag : b_mag;
          end else if (We) begin
            if (HorL) hi_q <= A;
            else      lo_q <= A;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (mul_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else begin
            // Divide by zero leaves |A| as remainder; its sign fix restores A.
            hi_q <= rem_fix;
            lo_q <= dz_q ? '1 : quo_fix;
          end
          ready_q <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Ready = ready_q;
  assign Busy  = (state_q != ST_IDLE);
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign Out   = HorL ? hi_q : lo_q;

endmodule

// File: tb/tb_coco_muldiv_seq.sv
// Directed-vector bench for the HI/LO multiply/divide sequencer.
// Each task drives one scenario and checks against hand-computed values.
module tb_coco_muldiv_seq;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        MorD;
  logic        HorL;
  logic        Sign;
  logic        We;
  logic [31:0] A;
  logic [31:0] B;
  logic        Ready;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  int vectors     = 0;
  int miscompares = 0;

  coco_muldiv_seq #(
    .WIDTH (32)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .MorD  (MorD),
    .HorL  (HorL),
    .Sign  (Sign),
    .We    (We),
    .A     (A),
    .B     (B),
    .Ready (Ready),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO),
    .Out   (Out)
  );

  always #5 Clk = ~Clk;

  // Launch one operation, scramble A/B after accept, watch 40 cycles.
  // lat is the cycle index (1 = cycle after accept) where Ready is seen.
  task automatic run_op(
    input  logic        md,
    input  logic        sg,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  bit          hold,
    output int          lat,
    output int          busy_n,
    output int          pulses,
    output logic [31:0] rhi,
    output logic [31:0] rlo,
    output logic [31:0] rout
  );
    @(negedge Clk);
    MorD = md; Sign = sg; A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    if (!hold) Start = 1'b0;
    A = ~a; B = 32'h5;
    lat = -1; busy_n = 0; pulses = 0;
    rhi = '0; rlo = '0; rout = '0;
    for (int i = 1; i <= 40; i++) begin
      if (Busy) busy_n++;
      if (Ready) begin
        pulses++;
        if (lat < 0) begin
          lat = i; rhi = HI; rlo = LO; rout = Out;
        end
        Start = 1'b0;
      end
      @(posedge Clk); #1;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; MorD = 1'b0; HorL = 1'b0;
    Sign = 1'b0; We = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if (Ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", Ready); end
    vectors++;
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", Busy); end
    vectors++;
    if (HI !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", HI); end
    vectors++;
    if (LO !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", LO); end
    Reset = 1'b0;
  endtask

  task automatic test_mul_signed;
    int lat, bn, pl;
    logic [31:0] h, l, o;
    HorL = 1'b0;
    run_op(1'b1, 1'b0, 32'hFFFFFFFE, 32'd3, 1'b1, lat, bn, pl, h, l, o);
    vectors++;
    if (lat !== 34) begin miscompares++; $display("FAIL muls_latency: got %0d want 34", lat); end
    vectors++;
    if (bn !== 34) begin miscompares++; $display("FAIL muls_busy: got %0d want 34", bn); end
    vectors++;
    if (pl !== 1) begin miscompares++; $display("FAIL muls_pulses: got %0d want 1", pl); end
    vectors++;
    if (h !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL muls_hi: got %h want ffffffff", h); end
    vectors++;
    if (l !== 32'hFFFFFFFA) begin miscompares++; $display("FAIL muls_lo: got %h want fffffffa", l); end
    vectors++;
    if (o !== 32'hFFFFFFFA) begin miscompares++; $display("FAIL muls_out: got %h want fffffffa", o); end
  endtask

  task automatic test_mul_unsigned;
    int lat, bn, pl;
    logic [31:0] h, l, o;
    HorL = 1'b1;
    run_op(1'b1, 1'b1, 32'hFFFFFFFE, 32'd3, 1'b0, lat, bn, pl, h, l, o);
    vectors++;
    if (h !== 32'h00000002) begin miscompares++; $display("FAIL mulu_hi: got %h want 00000002", h); end
    vectors++;
    if (l !== 32'hFFFFFFFA) begin miscompares++; $display("FAIL mulu_lo: got %h want fffffffa", l); end
    vectors++;
    if (o !== 32'h00000002) begin miscompares++; $display("FAIL mulu_out: got %h want 00000002", o); end
  endtask

  task automatic test_div_signed;
    int lat, bn, pl;
    logic [31:0] h, l, o;
    run_op(1'b0, 1'b0, 32'hFFFFFFF9, 32'd2, 1'b0, lat, bn, pl, h, l, o);
    vectors++;
    if (l !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL divs_lo: got %h want fffffffd", l); end
    vectors++;
    if (h !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL divs_hi: got %h want ffffffff", h); end
  endtask

  task automatic test_div_unsigned;
    int lat, bn, pl;
    logic [31:0] h, l, o;
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, lat, bn, pl, h, l, o);
    vectors++;
    if (l !== 32'd14) begin miscompares++; $display("FAIL divu_lo: got %h want 0000000e", l); end
    vectors++;
    if (h !== 32'd2) begin miscompares++; $display("FAIL divu_hi: got %h want 00000002", h); end
    vectors++;
    if (lat !== 34) begin miscompares++; $display("FAIL divu_latency: got %0d want 34", lat); end
  endtask

  task automatic test_div_zero;
    int lat, bn, pl;
    logic [31:0] h, l, o;
    for (int s = 0; s < 2; s++) begin
      run_op(1'b0, 1'(s), 32'h12345678, 32'h0, 1'b0, lat, bn, pl, h, l, o);
      vectors++;
      if (l !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL dz_lo sign=%0d: got %h want ffffffff", s, l); end
      vectors++;
      if (h !== 32'h12345678) begin miscompares++; $display("FAIL dz_hi sign=%0d: got %h want 12345678", s, h); end
      vectors++;
      if (lat !== 34) begin miscompares++; $display("FAIL dz_latency sign=%0d: got %0d want 34", s, lat); end
    end
    run_op(1'b0, 1'b0, 32'hFFFFFFF9, 32'h0, 1'b0, lat, bn, pl, h, l, o);
    vectors++;
    if (l !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL dz_neg_lo: got %h want ffffffff", l); end
    vectors++;
    if (h !== 32'hFFFFFFF9) begin miscompares++; $display("FAIL dz_neg_hi: got %h want fffffff9", h); end
  endtask

  task automatic test_overflow;
    int lat, bn, pl;
    logic [31:0] h, l, o;
    run_op(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bn, pl, h, l, o);
    vectors++;
    if (l !== 32'h80000000) begin miscompares++; $display("FAIL ovf_lo: got %h want 80000000", l); end
    vectors++;
    if (h !== 32'h0) begin miscompares++; $display("FAIL ovf_hi: got %h want 00000000", h); end
  endtask

  task automatic test_mthi;
    @(negedge Clk);
    We = 1'b1; HorL = 1'b0; A = 32'h0BADF00D;
    @(posedge Clk); #1;
    vectors++;
    if (LO !== 32'h0BADF00D) begin miscompares++; $display("FAIL mtlo_lo: got %h want 0badf00d", LO); end
    vectors++;
    if (HI !== 32'h0) begin miscompares++; $display("FAIL mtlo_hi: got %h want 00000000", HI); end
    @(negedge Clk);
    HorL = 1'b1; A = 32'hDEADBEEF;
    @(posedge Clk); #1;
    We = 1'b0;
    vectors++;
    if (HI !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mthi_hi: got %h want deadbeef", HI); end
    vectors++;
    if (LO !== 32'h0BADF00D) begin miscompares++; $display("FAIL mthi_lo: got %h want 0badf00d", LO); end
    vectors++;
    if (Out !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mthi_out: got %h want deadbeef", Out); end
  endtask

  task automatic test_we_busy;
    int n;
    @(negedge Clk);
    Start = 1'b1; We = 1'b1; HorL = 1'b1;
    MorD = 1'b1; Sign = 1'b1; A = 32'd7; B = 32'd6;
    @(posedge Clk); #1;
    Start = 1'b0; A = 32'h11111111;
    vectors++;
    if (HI !== 32'hDEADBEEF) begin miscompares++; $display("FAIL start_we_hi: got %h want deadbeef", HI); end
    repeat (3) @(posedge Clk);
    #1;
    vectors++;
    if (HI !== 32'hDEADBEEF) begin miscompares++; $display("FAIL busy_we_hi: got %h want deadbeef", HI); end
    HorL = 1'b0;
    @(posedge Clk); #1;
    vectors++;
    if (LO !== 32'h0BADF00D) begin miscompares++; $display("FAIL busy_we_lo: got %h want 0badf00d", LO); end
    We = 1'b0;
    n = 0;
    while (!Ready && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    vectors++;
    if (Ready !== 1'b1) begin miscompares++; $display("FAIL wb_ready: got %b want 1", Ready); end
    vectors++;
    if (LO !== 32'd42) begin miscompares++; $display("FAIL wb_lo: got %h want 0000002a", LO); end
    vectors++;
    if (HI !== 32'h0) begin miscompares++; $display("FAIL wb_hi: got %h want 00000000", HI); end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat, bn, pl;
    logic [31:0] h, l, o;
    @(negedge Clk);
    MorD = 1'b0; Sign = 1'b1; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    vectors++;
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", Busy); end
    vectors++;
    if (LO !== 32'h0) begin miscompares++; $display("FAIL rmid_lo: got %h want 00000000", LO); end
    vectors++;
    if (HI !== 32'h0) begin miscompares++; $display("FAIL rmid_hi: got %h want 00000000", HI); end
    pl = 0;
    for (int i = 0; i < 40; i++) begin
      if (Ready) pl++;
      @(posedge Clk); #1;
    end
    vectors++;
    if (pl !== 0) begin miscompares++; $display("FAIL rmid_pulses: got %0d want 0", pl); end
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b0, lat, bn, pl, h, l, o);
    vectors++;
    if (l !== 32'd14) begin miscompares++; $display("FAIL rmid_after_lo: got %h want 0000000e", l); end
    vectors++;
    if (h !== 32'd2) begin miscompares++; $display("FAIL rmid_after_hi: got %h want 00000002", h); end
    vectors++;
    if (lat !== 34) begin miscompares++; $display("FAIL rmid_after_latency: got %0d want 34", lat); end
  endtask

  initial begin
    test_reset();
    test_mul_signed();
    test_mul_unsigned();
    test_div_signed();
    test_div_unsigned();
    test_div_zero();
    test_overflow();
    test_mthi();
    test_we_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
